// File: rtl/button_ctrl_pkg.sv
// Shared definitions for the front-panel button controller: per-button FSM
// state encodings and a constant-width helper.
package button_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_HELD        = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } btn_state_e;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/button_ctrl_btn_fsm.sv
// One button: two-flop synchronizer, debounce/hold FSM with saturating tick
// counter, and registered level/pulse outputs.
module btn_fsm
  import button_ctrl_pkg::*;
#(
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int CW = clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LONG   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] CNT_REPEAT = CW'(REPEAT_TICKS - 1);

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          sync1_q, sync1_d;
  logic          s_q, s_d;
  logic          held_q, held_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  assign sync1_d = btn_raw;
  assign s_d     = sync1_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (s_q) begin
            state_d = ST_DEB_PRESS;
            cnt_d   = CNT_ONE;
          end
        end
        ST_DEB_PRESS: begin
          if (!s_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_STABLE) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!s_q) begin
            state_d = ST_DEB_RELEASE;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == CNT_LONG) begin
            state_d = ST_HELD;
            held_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HELD: begin
          if (!s_q) begin
            state_d = ST_DEB_RELEASE;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == CNT_REPEAT) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DEB_RELEASE: begin
          // A release bounce returns to wherever the press was, restarting its timer.
          if (s_q) begin
            state_d = held_q ? ST_HELD : ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_STABLE) begin
            state_d = ST_IDLE;
            held_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          held_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_DEB_PRESS: begin
          if (s_q && cnt_q == CNT_STABLE) begin
            level_d = 1'b1;
            press_d = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (s_q && cnt_q == CNT_LONG) long_d = 1'b1;
        end
        ST_HELD: begin
          if (s_q && cnt_q == CNT_REPEAT) repeat_d = 1'b1;
        end
        ST_DEB_RELEASE: begin
          if (!s_q && cnt_q == CNT_STABLE) begin
            level_d   = 1'b0;
            release_d = 1'b1;
          end
        end
        default: begin
          level_d = level_q;
        end
      endcase
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_ctrl.sv
// Front-panel button controller: one shared debounce prescaler driving an
// independent debounce/hold FSM per button.
module button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int TICK_HZ      = 1000,
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = clog2(DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [PW-1:0] div_q, div_d;

  always_ff @(posedge clk) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  always_comb begin
    div_d = tick ? '0 : div_q + PW'(1);
  end

  assign tick = (div_q == DIV_LAST);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_btn_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .btn_raw      (btn_in[i]),
      .level        (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with DIV=10, STABLE=3, LONG=10, REPEAT=4;
// cyc counts clk edges since the last reset edge.
module tb_button_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic       tick;
  logic [3:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  int press_cnt[4], press_last[4], release_cnt[4], release_last[4];
  int long_cnt[4], long_last[4], rep_cnt[4], rep_first[4], rep_last[4];
  int level_hi[4];
  int multi_pulse = 0;
  int tick_bad    = 0;
  int tick_cnt    = 0;
  int tick_first  = -1;

  button_ctrl #(
    .CLK_HZ(1000), .TICK_HZ(100), .N_BTN(4),
    .STABLE_TICKS(3), .LONG_TICKS(10), .REPEAT_TICKS(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .tick         (tick),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Event recorder: tick phase against cyc, plus per-bit pulse history.
  always @(negedge clk) begin
    logic exp_tick;
    if (mon_en) begin
      exp_tick = ((cyc % 10) == 9);
      if (tick !== exp_tick) tick_bad++;
      if (tick === 1'b1) begin
        tick_cnt++;
        if (tick_first < 0) tick_first = cyc;
      end
      for (int b = 0; b < 4; b++) begin
        if (press_pulse[b] === 1'b1)   begin press_cnt[b]++;   press_last[b]   = cyc; end
        if (release_pulse[b] === 1'b1) begin release_cnt[b]++; release_last[b] = cyc; end
        if (long_pulse[b] === 1'b1)    begin long_cnt[b]++;    long_last[b]    = cyc; end
        if (repeat_pulse[b] === 1'b1) begin
          if (rep_cnt[b] == 0) rep_first[b] = cyc;
          rep_cnt[b]++;
          rep_last[b] = cyc;
        end
        if (btn_level[b] === 1'b1) level_hi[b]++;
        if (int'(press_pulse[b]) + int'(release_pulse[b]) + int'(long_pulse[b])
            + int'(repeat_pulse[b]) > 1) multi_pulse++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] btn, input logic rst_val);
    btn_in = btn;
    rst_n  = rst_val;
  endtask

  task automatic runTo(input int k);
    if (cyc >= k) begin
      checkOutput("run_to_target", cyc, k);
    end else begin
      while (cyc < k) @(negedge clk);
    end
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int b = 0; b < 4; b++) begin
      press_cnt[b] = 0;  press_last[b] = -1;
      release_cnt[b] = 0; release_last[b] = -1;
      long_cnt[b] = 0;   long_last[b] = -1;
      rep_cnt[b] = 0;    rep_first[b] = -1; rep_last[b] = -1;
      level_hi[b] = 0;
    end
    applyStimulus(4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    mon_en = 1;
    checkOutput("reset_tick", tick, 0);
    checkOutput("reset_level", btn_level, 0);
    checkOutput("reset_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    applyStimulus(4'b0000, 1'b1);

    // Idle run: tick cadence, nothing else moves.
    runTo(100);
    checkOutput("idle_tick_count", tick_cnt, 10);
    checkOutput("idle_tick_first", tick_first, 9);
    checkOutput("idle_tick_phase", tick_bad, 0);
    checkOutput("idle_no_pulses", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                + release_cnt[0] + long_cnt[0] + rep_cnt[0], 0);
    checkOutput("idle_level", level_hi[0] + level_hi[1] + level_hi[2] + level_hi[3], 0);

    // Clean press and release on button 0.
    applyStimulus(4'b0001, 1'b1);
    runTo(139);
    checkOutput("b0_no_early_press", press_cnt[0], 0);
    checkOutput("b0_level_before", btn_level[0], 0);
    runTo(140);
    checkOutput("b0_press_pulse", press_pulse[0], 1);
    checkOutput("b0_level_pressed", btn_level[0], 1);
    runTo(141);
    checkOutput("b0_press_width", press_pulse[0], 0);
    runTo(175);
    applyStimulus(4'b0000, 1'b1);
    runTo(209);
    checkOutput("b0_level_deb_release", btn_level[0], 1);
    runTo(210);
    checkOutput("b0_release_pulse", release_pulse[0], 1);
    checkOutput("b0_level_released", btn_level[0], 0);
    checkOutput("b0_press_count", press_cnt[0], 1);
    checkOutput("b0_release_count", release_cnt[0], 1);
    checkOutput("b0_no_long", long_cnt[0], 0);

    // Button 1 bounces every 15 clk, then settles high.
    for (int i = 0; i < 14; i++) begin
      runTo(220 + 15 * i);
      applyStimulus({2'b00, (i % 2 == 0), 1'b0}, 1'b1);
    end
    runTo(420);
    checkOutput("b1_bounce_press", press_cnt[1], 0);
    checkOutput("b1_bounce_release", release_cnt[1], 0);
    checkOutput("b1_bounce_level", level_hi[1], 0);
    applyStimulus(4'b0010, 1'b1);
    runTo(460);
    checkOutput("b1_settled_press", press_pulse[1], 1);
    checkOutput("b1_press_count", press_cnt[1], 1);

    // Button 2 long hold: long after 10 ticks, then repeats every 4 ticks.
    runTo(470);
    applyStimulus(4'b0110, 1'b1);
    runTo(510);
    checkOutput("b2_press_pulse", press_pulse[2], 1);
    runTo(775);
    applyStimulus(4'b0010, 1'b1);
    runTo(810);
    checkOutput("b2_release_pulse", release_pulse[2], 1);
    checkOutput("b2_long_count", long_cnt[2], 1);
    checkOutput("b2_long_cycle", long_last[2], 610);
    checkOutput("b2_repeat_count", rep_cnt[2], 4);
    checkOutput("b2_repeat_first", rep_first[2], 650);
    checkOutput("b2_repeat_last", rep_last[2], 770);

    // Buttons 0 and 2 rise together.
    runTo(820);
    checkOutput("b2_no_late_repeat", rep_cnt[2], 4);
    applyStimulus(4'b0111, 1'b1);
    runTo(860);
    checkOutput("simul_press", press_pulse & 4'b0101, 4'b0101);
    checkOutput("simul_b0_count", press_cnt[0], 2);
    checkOutput("simul_b2_count", press_cnt[2], 2);

    // Reset while pressed, with button 3 held through reset.
    runTo(870);
    applyStimulus(4'b1000, 1'b0);
    waitCycles(1);
    checkOutput("rst1_level", btn_level, 0);
    checkOutput("rst1_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    checkOutput("rst1_tick", tick, 0);
    waitCycles(3);
    applyStimulus(4'b1000, 1'b1);
    runTo(39);
    checkOutput("b3_no_early_press", press_cnt[3], 0);
    runTo(40);
    checkOutput("b3_press_pulse", press_pulse[3], 1);
    checkOutput("b3_level", btn_level[3], 1);
    runTo(55);
    applyStimulus(4'b1000, 1'b0);
    waitCycles(1);
    checkOutput("rst2_level", btn_level, 0);
    checkOutput("rst2_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    waitCycles(2);
    applyStimulus(4'b0000, 1'b1);
    runTo(60);
    checkOutput("rst_no_release_b3", release_cnt[3], 0);
    checkOutput("rst_no_release_b0", release_cnt[0], 1);
    checkOutput("rst_no_release_b2", release_cnt[2], 1);
    checkOutput("b3_press_count", press_cnt[3], 1);
    checkOutput("one_pulse_per_bit", multi_pulse, 0);
    checkOutput("tick_phase_all", tick_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
